// File: rtl/dct_pkg.sv
// rtl/dct_pkg.sv - shared constants and types for the DCT transpose buffer
// Purpose: 8-point block geometry, default coefficient width, and the
//          row/column vector and index types used by the transpose slice.
// Ports:   none (package).
package dct_pkg;

  localparam int DCT_N      = 8;
  localparam int DCT_IDX_W  = 3;
  localparam int DCT_DATA_W = 32;

  typedef logic [DCT_IDX_W-1:0]        dct_idx_t;
  typedef logic [DCT_N*DCT_DATA_W-1:0] dct_vec_t;

endpackage

// File: rtl/dct_tp_bank.sv
// rtl/dct_tp_bank.sv - one 8x8 word bank, row write / column read
// Purpose: stores one 8x8 block of coefficient words in flops. Rows are
//          written whole; columns are read combinationally.
// Ports:
//   clk       in   clock, rising edge
//   i_we      in   write enable for one row
//   i_wr_row  in   row index written when i_we=1
//   i_wr_vec  in   row vector, word k at [k*DATA_WIDTH +: DATA_WIDTH]
//   i_rd_col  in   column index to read
//   o_rd_vec  out  column vector, word k = row k of the selected column
module dct_tp_bank
  import dct_pkg::*;
#(
  parameter int DATA_WIDTH = DCT_DATA_W
) (
  input  logic                        clk,
  input  logic                        i_we,
  input  logic [DCT_IDX_W-1:0]        i_wr_row,
  input  logic [DCT_N*DATA_WIDTH-1:0] i_wr_vec,
  input  logic [DCT_IDX_W-1:0]        i_rd_col,
  output logic [DCT_N*DATA_WIDTH-1:0] o_rd_vec
);

  // Word storage carries no reset: a block is only ever read after all
  // eight of its rows have been written.
  logic [DATA_WIDTH-1:0] r_mem [DCT_N][DCT_N];

  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int k = 0; k < DCT_N; k++) begin
        r_mem[i_wr_row][k] <= i_wr_vec[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Column read is the transpose: word k of the output comes from row k.
  always_comb begin
    o_rd_vec = '0;
    for (int k = 0; k < DCT_N; k++) begin
      o_rd_vec[k*DATA_WIDTH +: DATA_WIDTH] = r_mem[k][i_rd_col];
    end
  end

endmodule

// File: rtl/dct_transpose_8x8.sv
// rtl/dct_transpose_8x8.sv - ping-pong 8x8 transpose between DCT row and column passes
// Purpose: accepts one 8-word row per handshake; once a block is complete it
//          is presented column by column. Two banks let a new block be
//          written while the previous one drains, with no bubbles.
// Ports:
//   clk          in   clock, rising edge
//   reset        in   asynchronous active-high reset
//   in_valid     in   in_row holds a valid row
//   in_ready     out  a row can be accepted this cycle
//   in_row       in   row vector, word k at [k*DATA_WIDTH +: DATA_WIDTH]
//   out_valid    out  out_col holds a valid column
//   out_ready    in   consumer accepts out_col this cycle
//   out_col      out  column vector, word k = row k of the column
//   out_col_idx  out  index of the presented column
//   out_last     out  presented column is column 7 of its block
module dct_transpose_8x8
  import dct_pkg::*;
#(
  parameter int DATA_WIDTH = DCT_DATA_W
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_WIDTH*DCT_N-1:0] in_row,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_WIDTH*DCT_N-1:0] out_col,
  output logic [DCT_IDX_W-1:0]        out_col_idx,
  output logic                        out_last
);

  logic [1:0]           r_full;
  logic                 r_wr_bank;
  logic                 r_rd_bank;
  logic [DCT_IDX_W-1:0] r_wr_row;
  logic [DCT_IDX_W-1:0] r_rd_col;

  logic                        w_wr;
  logic                        w_rd;
  logic                        w_wr_done;
  logic                        w_rd_done;
  logic [1:0]                  w_full_nxt;
  logic [DATA_WIDTH*DCT_N-1:0] w_col0;
  logic [DATA_WIDTH*DCT_N-1:0] w_col1;

  assign in_ready  = !r_full[r_wr_bank];
  assign out_valid = r_full[r_rd_bank];
  assign w_wr      = in_valid && in_ready;
  assign w_rd      = out_valid && out_ready;
  assign w_wr_done = w_wr && (r_wr_row == DCT_IDX_W'(DCT_N - 1));
  assign w_rd_done = w_rd && (r_rd_col == DCT_IDX_W'(DCT_N - 1));

  // A write can only target an empty bank and a read only a full one, so a
  // simultaneous completion on both sides always touches different bits.
  always_comb begin
    w_full_nxt = r_full;
    if (w_wr_done) begin
      w_full_nxt[r_wr_bank] = 1'b1;
    end
    if (w_rd_done) begin
      w_full_nxt[r_rd_bank] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_full    <= '0;
      r_wr_bank <= 1'b0;
      r_rd_bank <= 1'b0;
      r_wr_row  <= '0;
      r_rd_col  <= '0;
    end else begin
      r_full <= w_full_nxt;
      if (w_wr) begin
        r_wr_row <= r_wr_row + 1'b1;
      end
      if (w_wr_done) begin
        r_wr_bank <= !r_wr_bank;
      end
      if (w_rd) begin
        r_rd_col <= r_rd_col + 1'b1;
      end
      if (w_rd_done) begin
        r_rd_bank <= !r_rd_bank;
      end
    end
  end

  dct_tp_bank #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_bank0 (
    .clk      (clk),
    .i_we     (w_wr && !r_wr_bank),
    .i_wr_row (r_wr_row),
    .i_wr_vec (in_row),
    .i_rd_col (r_rd_col),
    .o_rd_vec (w_col0)
  );

  dct_tp_bank #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_bank1 (
    .clk      (clk),
    .i_we     (w_wr && r_wr_bank),
    .i_wr_row (r_wr_row),
    .i_wr_vec (in_row),
    .i_rd_col (r_rd_col),
    .o_rd_vec (w_col1)
  );

  // Outputs are zeroed when nothing is presented so stale bank contents
  // never leak onto the column bus.
  assign out_col     = !out_valid ? '0 : (r_rd_bank ? w_col1 : w_col0);
  assign out_col_idx = out_valid ? r_rd_col : '0;
  assign out_last    = out_valid && (r_rd_col == DCT_IDX_W'(DCT_N - 1));

endmodule

// File: tb/tb_dct_transpose_8x8.sv
// tb/tb_dct_transpose_8x8.sv - directed and randomized bench for dct_transpose_8x8
module tb_dct_transpose_8x8;

  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [DW*8-1:0] in_row = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [DW*8-1:0] out_col;
  logic [2:0]      out_col_idx;
  logic            out_last;

  dct_transpose_8x8 #(
    .DATA_WIDTH (DW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_row      (in_row),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_col     (out_col),
    .out_col_idx (out_col_idx),
    .out_last    (out_last)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW*8-1:0] col;
    logic [2:0]      idx;
  } exp_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t exp_q[$];
  logic [DW*8-1:0] mrows [8];
  int   mr = 0;
  int   feed_blk = 0;
  int   feed_row = 0;

  logic            hs_in, hs_out;
  logic            cap_in_ready, cap_out_valid, cap_last;
  logic [DW*8-1:0] cap_col;
  logic [2:0]      cap_idx;

  // Word (r,c) of block b carries its own coordinates.
  function automatic logic [DW*8-1:0] make_row(int b, int r);
    logic [DW*8-1:0] v;
    for (int c = 0; c < 8; c++) v[c*DW +: DW] = 32'(b*256 + 16*r + c);
    return v;
  endfunction

  // One clock: drive the current row, sample outputs before the edge,
  // advance the feeder and the transpose model on accepted rows.
  task automatic step();
    logic [DW*8-1:0] col;
    in_row = in_valid ? make_row(feed_blk, feed_row) : {8{$urandom()}};
    #1;
    cap_in_ready  = in_ready;
    cap_out_valid = out_valid;
    cap_col       = out_col;
    cap_idx       = out_col_idx;
    cap_last      = out_last;
    hs_in  = in_valid && in_ready;
    hs_out = out_valid && out_ready;
    @(posedge clk);
    #1;
    if (hs_in) begin
      mrows[mr] = in_row;
      mr++;
      feed_row++;
      if (feed_row == 8) begin
        feed_row = 0;
        feed_blk++;
      end
      if (mr == 8) begin
        for (int c = 0; c < 8; c++) begin
          for (int k = 0; k < 8; k++) col[k*DW +: DW] = mrows[k][c*DW +: DW];
          exp_q.push_back('{col: col, idx: 3'(c)});
        end
        mr = 0;
      end
    end
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    mr       = 0;
    feed_row = 0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      step();
      n_tests++;
      if (cap_in_ready !== 1'b1 || cap_out_valid !== 1'b0 || cap_col !== '0 ||
          cap_idx !== 3'd0 || cap_last !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_idle: cyc %0d in_ready %b out_valid %b idx %0d last %b col %h, expected 1 0 0 0 0",
                 i, cap_in_ready, cap_out_valid, cap_idx, cap_last, cap_col);
      end
    end
  endtask

  task automatic test_one_block();
    logic [DW*8-1:0] ec;
    int got;
    do_reset();
    feed_blk  = 0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int r = 0; r < 8; r++) begin
      step();
      n_tests++;
      if (cap_out_valid !== 1'b0 || hs_in !== 1'b1) begin
        n_fail++;
        $display("FAIL one_block_write: row %0d out_valid %b accepted %b, expected 0 1", r, cap_out_valid, hs_in);
      end
    end
    in_valid = 1'b0;
    n_tests++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL one_block_latency: out_valid %b one clk after row 7, expected 1", out_valid);
    end
    got = 0;
    for (int cyc = 0; cyc < 20 && got < 8; cyc++) begin
      step();
      if (hs_out) begin
        for (int k = 0; k < 8; k++) ec[k*DW +: DW] = 32'(16*k + got);
        n_tests++;
        if (cap_col !== ec || cap_idx !== 3'(got) || cap_last !== (got == 7)) begin
          n_fail++;
          $display("FAIL one_block_col: idx %0d last %b col %h, expected idx %0d last %b col %h",
                   cap_idx, cap_last, cap_col, got, (got == 7), ec);
        end
        got++;
      end
    end
    exp_q.delete();
    n_tests++;
    if (got != 8) begin
      n_fail++;
      $display("FAIL one_block_count: %0d columns, expected 8", got);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int got = 0;
    bit dropped = 0;
    bit gap = 0;
    do_reset();
    feed_blk  = 1;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 200 && got < 24; cyc++) begin
      in_valid = (feed_blk < 4);
      step();
      if (in_valid && !cap_in_ready) dropped = 1;
      if (got > 0 && !cap_out_valid) gap = 1;
      if (hs_out) begin
        got++;
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL b2b_col: unexpected column idx %0d", cap_idx);
        end else begin
          e = exp_q.pop_front();
          if (cap_col !== e.col || cap_idx !== e.idx || cap_last !== (e.idx == 3'd7)) begin
            n_fail++;
            $display("FAIL b2b_col: idx %0d last %b col %h, expected idx %0d col %h",
                     cap_idx, cap_last, cap_col, e.idx, e.col);
          end
        end
      end
    end
    in_valid = 1'b0;
    n_tests++;
    if (dropped) begin
      n_fail++;
      $display("FAIL b2b_in_ready: in_ready dropped %b, expected 0", dropped);
    end
    n_tests++;
    if (gap) begin
      n_fail++;
      $display("FAIL b2b_gap: out_valid gap %b, expected 0", gap);
    end
    n_tests++;
    if (got != 24) begin
      n_fail++;
      $display("FAIL b2b_count: %0d columns, expected 24", got);
    end
  endtask

  task automatic test_backpressure();
    exp_t e;
    logic [DW*8-1:0] held;
    int got = 0;
    do_reset();
    feed_blk  = 10;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      step();
      n_tests++;
      if (cap_in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL bp_fill: row %0d in_ready %b, expected 1", i, cap_in_ready);
      end
    end
    step();
    n_tests++;
    if (cap_in_ready !== 1'b0 || cap_out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_row17: in_ready %b out_valid %b, expected 0 1", cap_in_ready, cap_out_valid);
    end
    held = cap_col;
    for (int i = 0; i < 4; i++) begin
      step();
      n_tests++;
      if (cap_col !== held || cap_idx !== 3'd0 || cap_in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_stable: col %h idx %0d in_ready %b, expected col %h idx 0 in_ready 0",
                 cap_col, cap_idx, cap_in_ready, held);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 40 && got < 16; cyc++) begin
      step();
      if (hs_out) begin
        got++;
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL bp_col: unexpected column idx %0d", cap_idx);
        end else begin
          e = exp_q.pop_front();
          if (cap_col !== e.col || cap_idx !== e.idx || cap_last !== (e.idx == 3'd7)) begin
            n_fail++;
            $display("FAIL bp_col: idx %0d last %b col %h, expected idx %0d col %h",
                     cap_idx, cap_last, cap_col, e.idx, e.col);
          end
        end
        if (got == 8) begin
          n_tests++;
          if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release: in_ready %b after column 7 of block 0, expected 1", in_ready);
          end
        end
      end
    end
    n_tests++;
    if (got != 16) begin
      n_fail++;
      $display("FAIL bp_count: %0d columns, expected 16", got);
    end
  endtask

  task automatic test_random();
    exp_t e;
    int got = 0;
    do_reset();
    feed_blk = 100;
    for (int cyc = 0; cyc < 30000 && got < 800; cyc++) begin
      in_valid  = (feed_blk < 200) ? 1'($urandom_range(0, 1)) : 1'b0;
      out_ready = 1'($urandom_range(0, 1));
      step();
      if (hs_out) begin
        got++;
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL rand_col: unexpected column idx %0d", cap_idx);
        end else begin
          e = exp_q.pop_front();
          if (cap_col !== e.col || cap_idx !== e.idx || cap_last !== (e.idx == 3'd7)) begin
            n_fail++;
            $display("FAIL rand_col: idx %0d last %b col %h, expected idx %0d col %h",
                     cap_idx, cap_last, cap_col, e.idx, e.col);
          end
        end
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    n_tests++;
    if (got != 800 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL rand_count: %0d columns, %0d pending, expected 800 and 0", got, exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int got = 0;
    do_reset();
    feed_blk  = 300;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    repeat (10) step();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      if (hs_out) begin
        n_tests++;
        e = exp_q.pop_front();
        if (cap_col !== e.col || cap_idx !== e.idx) begin
          n_fail++;
          $display("FAIL mid_pre_col: idx %0d col %h, expected idx %0d col %h", cap_idx, cap_col, e.idx, e.col);
        end
      end
    end
    n_tests++;
    if (out_col_idx !== 3'd3 || feed_row != 5) begin
      n_fail++;
      $display("FAIL mid_setup: idx %0d rows %0d, expected 3 5", out_col_idx, feed_row);
    end
    #2;
    reset = 1'b1;
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || out_col !== '0 || out_col_idx !== 3'd0 || out_last !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_async: out_valid %b idx %0d last %b in_ready %b col %h, expected 0 0 0 1 0",
               out_valid, out_col_idx, out_last, in_ready, out_col);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    mr       = 0;
    feed_row = 0;
    feed_blk = 400;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
      in_valid = (feed_blk < 401);
      step();
      if (hs_out) begin
        got++;
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL mid_col: unexpected column idx %0d", cap_idx);
        end else begin
          e = exp_q.pop_front();
          if (cap_col !== e.col || cap_idx !== e.idx || cap_last !== (e.idx == 3'd7)) begin
            n_fail++;
            $display("FAIL mid_col: idx %0d last %b col %h, expected idx %0d col %h",
                     cap_idx, cap_last, cap_col, e.idx, e.col);
          end
        end
      end
    end
    in_valid = 1'b0;
    n_tests++;
    if (got != 8) begin
      n_fail++;
      $display("FAIL mid_count: %0d columns, expected 8", got);
    end
  endtask

  initial begin
    test_reset();
    test_one_block();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
